// File: rtl/uart_rx_pkg.sv
// Shared types and default sizes for the UART RX queue controller and its FIFO.
package uart_rx_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;
  localparam int unsigned DEFAULT_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    FLUSH
  } rxq_state_e;

  // Saturating 8-bit increment used for event counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_idle_timer.sv
// Character-timeout counter: saturating idle count, cleared on activity, IRQ while pending.
module rx_idle_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic CLKip,
  input  logic RSTNi,
  input  logic clr_i,
  input  logic pending_i,
  output logic irq_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      cnt_q <= '0;
    end else if (clr_i || !pending_i) begin
      cnt_q <= '0;
    end else if (cnt_q != LIMIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign irq_o = pending_i && (cnt_q == LIMIT);

endmodule

// File: rtl/uart_rx_fifo_ctrl.sv
// UART RX -> FIFO -> host stream controller with overrun, threshold IRQ and flush.
// Optional character timeout is built when RX_TIMEOUT_EN is defined.
module uart_rx_fifo_ctrl
  import uart_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH     = DEFAULT_FIFO_DEPTH,
  parameter int unsigned LOG2_DEPTH     = $clog2(FIFO_DEPTH),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLKip,
  input  logic                  RSTNi,
  input  logic                  RX_VALIDi,
  input  logic [DATA_WIDTH-1:0] RX_DATAi,
  output logic                  FIFO_WEo,
  output logic [DATA_WIDTH-1:0] FIFO_WDATAo,
  output logic                  FIFO_RDo,
  input  logic [DATA_WIDTH-1:0] FIFO_RDATAi,
  input  logic                  FIFO_EMPTYi,
  output logic                  M_VALIDo,
  output logic [DATA_WIDTH-1:0] M_DATAo,
  input  logic                  M_READYi,
  input  logic                  FLUSHi,
  input  logic [LOG2_DEPTH:0]   THRESHi,
  input  logic                  OVR_CLRi,
  output logic [LOG2_DEPTH:0]   LEVELo,
  output logic                  OVERRUNo,
  output logic [7:0]            DROP_CNTo,
  output logic                  IRQ_THRo,
  output logic                  TOUT_IRQo
);

  localparam logic [LOG2_DEPTH:0] FULL_LEVEL = (LOG2_DEPTH + 1)'(FIFO_DEPTH);

  rxq_state_e            state_q;
  logic [LOG2_DEPTH:0]   level_q, level_d;
  logic                  m_valid_q;
  logic [DATA_WIDTH-1:0] m_data_q;
  logic                  ovr_q;
  logic [7:0]            drop_q;
  logic                  irq_q;

  logic full, fifo_we, fifo_rd, drop;

  assign full    = (level_q == FULL_LEVEL);
  assign fifo_we = RX_VALIDi && !full && (state_q != FLUSH);
  assign drop    = RX_VALIDi && full && (state_q != FLUSH);

  // Reads are issued combinationally so the registered FIFO data lands during FETCH.
  always_comb begin
    fifo_rd = 1'b0;
    case (state_q)
      IDLE:    fifo_rd = !FIFO_EMPTYi && !FLUSHi;
      HOLD:    fifo_rd = !FIFO_EMPTYi && !FLUSHi && M_READYi;
      FLUSH:   fifo_rd = !FIFO_EMPTYi;
      default: fifo_rd = 1'b0;
    endcase
  end

  always_comb begin
    level_d = level_q;
    if (fifo_we && !fifo_rd) begin
      level_d = level_q + 1'b1;
    end else if (!fifo_we && fifo_rd) begin
      level_d = level_q - 1'b1;
    end
  end

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      level_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      irq_q   <= (THRESHi != '0) && (level_d >= THRESHi);
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      ovr_q  <= 1'b0;
      drop_q <= '0;
    end else if (drop) begin
      ovr_q  <= 1'b1;
      drop_q <= OVR_CLRi ? 8'd1 : sat_inc8(drop_q);
    end else if (OVR_CLRi) begin
      ovr_q  <= 1'b0;
      drop_q <= '0;
    end
  end

  always_ff @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      state_q   <= IDLE;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (FLUSHi) begin
      state_q   <= FLUSH;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!FIFO_EMPTYi) state_q <= FETCH;
        end
        FETCH: begin
          m_data_q  <= FIFO_RDATAi;
          m_valid_q <= 1'b1;
          state_q   <= HOLD;
        end
        HOLD: begin
          if (M_READYi) begin
            m_valid_q <= 1'b0;
            state_q   <= FIFO_EMPTYi ? IDLE : FETCH;
          end
        end
        FLUSH: begin
          if ((level_q == '0) && FIFO_EMPTYi) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef RX_TIMEOUT_EN
  logic pending, idle_clr;

  assign pending  = (level_q != '0) || m_valid_q;
  assign idle_clr = RX_VALIDi || (m_valid_q && M_READYi) || FLUSHi || (state_q == FLUSH);

  rx_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .CLKip    (CLKip),
    .RSTNi    (RSTNi),
    .clr_i    (idle_clr),
    .pending_i(pending),
    .irq_o    (TOUT_IRQo)
  );
`else
  assign TOUT_IRQo = 1'b0;
`endif

  assign FIFO_WEo    = fifo_we;
  assign FIFO_WDATAo = RX_DATAi;
  assign FIFO_RDo    = fifo_rd;
  assign M_VALIDo    = m_valid_q;
  assign M_DATAo     = m_data_q;
  assign LEVELo      = level_q;
  assign OVERRUNo    = ovr_q;
  assign DROP_CNTo   = drop_q;
  assign IRQ_THRo    = irq_q;

endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Bench for uart_rx_fifo_ctrl: a queue-based FIFO plus a stream/occupancy reference model.
module tb_uart_rx_fifo_ctrl;

  localparam int DEPTH = 16;

  logic       CLKip = 1'b0;
  logic       RSTNi = 1'b1;
  logic       RX_VALIDi = 1'b0;
  logic [7:0] RX_DATAi = '0;
  logic       FIFO_WEo;
  logic [7:0] FIFO_WDATAo;
  logic       FIFO_RDo;
  logic [7:0] fifo_rdata = '0;
  logic       fifo_empty = 1'b1;
  logic       M_VALIDo;
  logic [7:0] M_DATAo;
  logic       M_READYi = 1'b0;
  logic       FLUSHi = 1'b0;
  logic [4:0] THRESHi = '0;
  logic       OVR_CLRi = 1'b0;
  logic [4:0] LEVELo;
  logic       OVERRUNo;
  logic [7:0] DROP_CNTo;
  logic       IRQ_THRo;
  logic       TOUT_IRQo;

  int total = 0;
  int bad = 0;

  // Reference state
  logic [7:0] fifo_q[$];
  logic [7:0] exp_log[$];
  logic [7:0] got_q[$];
  bit  m_ovr;
  int  m_drop;
  bit  m_flushing;
  int  hs_cnt;
  int  rd_pulses;
  int  pre_size;

  uart_rx_fifo_ctrl #(
    .DATA_WIDTH    (8),
    .FIFO_DEPTH    (DEPTH),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .CLKip      (CLKip),
    .RSTNi      (RSTNi),
    .RX_VALIDi  (RX_VALIDi),
    .RX_DATAi   (RX_DATAi),
    .FIFO_WEo   (FIFO_WEo),
    .FIFO_WDATAo(FIFO_WDATAo),
    .FIFO_RDo   (FIFO_RDo),
    .FIFO_RDATAi(fifo_rdata),
    .FIFO_EMPTYi(fifo_empty),
    .M_VALIDo   (M_VALIDo),
    .M_DATAo    (M_DATAo),
    .M_READYi   (M_READYi),
    .FLUSHi     (FLUSHi),
    .THRESHi    (THRESHi),
    .OVR_CLRi   (OVR_CLRi),
    .LEVELo     (LEVELo),
    .OVERRUNo   (OVERRUNo),
    .DROP_CNTo  (DROP_CNTo),
    .IRQ_THRo   (IRQ_THRo),
    .TOUT_IRQo  (TOUT_IRQo)
  );

  always #5 CLKip = ~CLKip;

  // FIFO environment plus the expected host stream and overrun bookkeeping.
  always @(posedge CLKip or negedge RSTNi) begin
    if (!RSTNi) begin
      fifo_q.delete();
      exp_log.delete();
      got_q.delete();
      fifo_rdata <= '0;
      fifo_empty <= 1'b1;
      m_ovr = 0;
      m_drop = 0;
      m_flushing = 0;
      hs_cnt = 0;
      rd_pulses = 0;
    end else begin
      pre_size = fifo_q.size();
      if (M_VALIDo && M_READYi && !FLUSHi) begin
        got_q.push_back(M_DATAo);
        hs_cnt++;
      end
      if (FIFO_RDo) begin
        rd_pulses++;
        if (fifo_q.size() != 0) fifo_rdata <= fifo_q.pop_front();
      end
      if (FIFO_WEo) fifo_q.push_back(FIFO_WDATAo);
      fifo_empty <= (fifo_q.size() == 0);
      if (OVR_CLRi) begin
        m_ovr = 0;
        m_drop = 0;
      end
      if (RX_VALIDi && !m_flushing) begin
        if (pre_size == DEPTH) begin
          m_ovr = 1;
          if (m_drop < 255) m_drop++;
        end else begin
          exp_log.push_back(RX_DATAi);
        end
      end
      if (m_flushing && pre_size == 0) m_flushing = 0;
      if (FLUSHi) begin
        m_flushing = 1;
        while (exp_log.size() > got_q.size()) void'(exp_log.pop_back());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLKip);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b1;
    RX_DATAi  = b;
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge CLKip);
    total++;
    if ({FIFO_WEo, FIFO_RDo, M_VALIDo, OVERRUNo, IRQ_THRo, TOUT_IRQo} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000000",
               {FIFO_WEo, FIFO_RDo, M_VALIDo, OVERRUNo, IRQ_THRo, TOUT_IRQo});
    end
    total++;
    if ({M_DATAo, LEVELo, DROP_CNTo} !== 21'b0) begin
      bad++;
      $display("FAIL reset_values data=%h level=%0d drop=%0d want all 0", M_DATAo, LEVELo,
               DROP_CNTo);
    end
    @(posedge CLKip); #1;
    RSTNi = 1'b1;
    @(negedge CLKip);
    total++;
    if ({M_VALIDo, LEVELo} !== 6'b0) begin
      bad++;
      $display("FAIL reset_release valid=%b level=%0d want 0/0", M_VALIDo, LEVELo);
    end
  endtask

  task automatic test_in_order();
    logic [7:0] want[3];
    want[0] = 8'hA1; want[1] = 8'hA2; want[2] = 8'hA3;
    M_READYi = 1'b1;
    send(want[0]);
    @(negedge CLKip);
    @(negedge CLKip);
    total++;
    if (M_VALIDo !== 1'b0) begin
      bad++;
      $display("FAIL latency_early valid=%b want 0", M_VALIDo);
    end
    @(negedge CLKip);
    total++;
    if (M_VALIDo !== 1'b1 || M_DATAo !== 8'hA1) begin
      bad++;
      $display("FAIL latency_first valid=%b data=%h want 1/a1", M_VALIDo, M_DATAo);
    end
    idle(2);
    send(want[1]);
    idle(3);
    send(want[2]);
    idle(8);
    @(negedge CLKip);
    total++;
    if (got_q.size() != 3) begin
      bad++;
      $display("FAIL in_order_count got=%0d want=3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (got_q[i] !== want[i]) begin
          bad++;
          $display("FAIL in_order_byte%0d got=%h want=%h", i, got_q[i], want[i]);
        end
      end
    end
    total++;
    if (LEVELo !== 5'd0) begin
      bad++;
      $display("FAIL in_order_level got=%0d want=0", LEVELo);
    end
  endtask

  task automatic test_hold();
    int h0;
    M_READYi = 1'b0;
    send(8'h5C);
    idle(3);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLKip);
      total++;
      if (M_VALIDo !== 1'b1 || M_DATAo !== 8'h5C) begin
        bad++;
        $display("FAIL hold_stable cyc=%0d valid=%b data=%h want 1/5c", i, M_VALIDo, M_DATAo);
      end
`ifndef RX_TIMEOUT_EN
      total++;
      if (TOUT_IRQo !== 1'b0) begin
        bad++;
        $display("FAIL tout_tied got=%b want=0", TOUT_IRQo);
      end
`endif
    end
    h0 = hs_cnt;
    @(posedge CLKip); #1;
    M_READYi = 1'b1;
    idle(4);
    M_READYi = 1'b0;
    @(negedge CLKip);
    total++;
    if (hs_cnt - h0 != 1 || M_VALIDo !== 1'b0) begin
      bad++;
      $display("FAIL hold_release handshakes=%0d valid=%b want 1/0", hs_cnt - h0, M_VALIDo);
    end
  endtask

  task automatic test_overrun();
    logic [7:0] first;
    M_READYi = 1'b0;
    first = 8'($urandom);
    send(first);
    idle(3);
    for (int i = 1; i < 18; i++) begin
      send(8'($urandom));
      idle(3);
    end
    @(negedge CLKip);
    total++;
    if (LEVELo !== 5'd16 || OVERRUNo !== 1'b1 || DROP_CNTo !== 8'd1) begin
      bad++;
      $display("FAIL overrun_state level=%0d ovr=%b drop=%0d want 16/1/1", LEVELo, OVERRUNo,
               DROP_CNTo);
    end
    total++;
    if (M_VALIDo !== 1'b1 || M_DATAo !== first) begin
      bad++;
      $display("FAIL overrun_held valid=%b data=%h want 1/%h", M_VALIDo, M_DATAo, first);
    end
    // Drop and clear in the same cycle
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b1;
    RX_DATAi  = 8'($urandom);
    OVR_CLRi  = 1'b1;
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b0;
    OVR_CLRi  = 1'b0;
    @(negedge CLKip);
    total++;
    if (OVERRUNo !== 1'b1 || DROP_CNTo !== 8'd1) begin
      bad++;
      $display("FAIL drop_beats_clear ovr=%b drop=%0d want 1/1", OVERRUNo, DROP_CNTo);
    end
    @(posedge CLKip); #1;
    OVR_CLRi = 1'b1;
    @(posedge CLKip); #1;
    OVR_CLRi = 1'b0;
    @(negedge CLKip);
    total++;
    if (OVERRUNo !== 1'b0 || DROP_CNTo !== 8'd0) begin
      bad++;
      $display("FAIL ovr_clear ovr=%b drop=%0d want 0/0", OVERRUNo, DROP_CNTo);
    end
  endtask

  task automatic test_flush_full();
    int r0;
    r0 = rd_pulses;
    @(posedge CLKip); #1;
    FLUSHi = 1'b1;
    @(posedge CLKip); #1;
    FLUSHi    = 1'b0;
    RX_VALIDi = 1'b1;
    RX_DATAi  = 8'($urandom);
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b0;
    idle(25);
    @(negedge CLKip);
    total++;
    if (OVERRUNo !== 1'b0 || DROP_CNTo !== 8'd0) begin
      bad++;
      $display("FAIL flush_silent_drop ovr=%b drop=%0d want 0/0", OVERRUNo, DROP_CNTo);
    end
    total++;
    if (LEVELo !== 5'd0 || M_VALIDo !== 1'b0 || rd_pulses - r0 != 16) begin
      bad++;
      $display("FAIL flush_full level=%0d valid=%b reads=%0d want 0/0/16", LEVELo, M_VALIDo,
               rd_pulses - r0);
    end
  endtask

  task automatic test_flush();
    int r0;
    M_READYi = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send(8'($urandom));
      idle(3);
    end
    @(negedge CLKip);
    total++;
    if (LEVELo !== 5'd4 || M_VALIDo !== 1'b1) begin
      bad++;
      $display("FAIL flush_setup level=%0d valid=%b want 4/1", LEVELo, M_VALIDo);
    end
    r0 = rd_pulses;
    @(posedge CLKip); #1;
    FLUSHi = 1'b1;
    @(posedge CLKip); #1;
    FLUSHi    = 1'b0;
    RX_VALIDi = 1'b1;
    RX_DATAi  = 8'($urandom);
    @(posedge CLKip); #1;
    RX_VALIDi = 1'b0;
    idle(12);
    @(negedge CLKip);
    total++;
    if (rd_pulses - r0 < 4 || rd_pulses - r0 > 5) begin
      bad++;
      $display("FAIL flush_reads got=%0d want 4..5", rd_pulses - r0);
    end
    total++;
    if (M_VALIDo !== 1'b0 || LEVELo !== 5'd0 || OVERRUNo !== 1'b0) begin
      bad++;
      $display("FAIL flush_end valid=%b level=%0d ovr=%b want 0/0/0", M_VALIDo, LEVELo,
               OVERRUNo);
    end
  endtask

  task automatic test_threshold();
    THRESHi = 5'd4;
    for (int c = 0; c < 64; c++) begin
      @(posedge CLKip); #1;
      RX_VALIDi = (c % 4 == 0) && (c < 24);
      RX_DATAi  = 8'($urandom);
      M_READYi  = (c >= 32);
      @(negedge CLKip);
      total++;
      if (IRQ_THRo !== (fifo_q.size() >= 4)) begin
        bad++;
        $display("FAIL irq_thr cyc=%0d got=%b want=%b level=%0d", c, IRQ_THRo,
                 fifo_q.size() >= 4, fifo_q.size());
      end
    end
    THRESHi = 5'd0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev_d;
    bit prev_v, prev_hs;
    int thr, fails;
    thr = $urandom_range(1, 16);
    THRESHi = 5'(thr);
    prev_v = 0; prev_hs = 0; prev_d = '0;
    for (int c = 0; c < 700; c++) begin
      @(posedge CLKip); #1;
      RX_VALIDi = (c < 660) && ($urandom % 3 == 0);
      RX_DATAi  = 8'($urandom);
      M_READYi  = (c < 300) ? ($urandom % 5 == 0) : ($urandom % 2 == 0);
      OVR_CLRi  = ($urandom % 60 == 0);
      FLUSHi    = ($urandom % 97 == 0);
      @(negedge CLKip);
      total++;
      if (LEVELo !== fifo_q.size()) begin
        bad++;
        $display("FAIL rnd_level cyc=%0d got=%0d want=%0d", c, LEVELo, fifo_q.size());
      end
      total++;
      if (FIFO_WEo !== (RX_VALIDi && !m_flushing && fifo_q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rnd_we cyc=%0d got=%b level=%0d", c, FIFO_WEo, fifo_q.size());
      end
      total++;
      if (FIFO_RDo && fifo_empty) begin
        bad++;
        $display("FAIL rnd_rd_empty cyc=%0d got rd=1 want 0", c);
      end
      total++;
      if (OVERRUNo !== m_ovr || DROP_CNTo !== m_drop) begin
        bad++;
        $display("FAIL rnd_overrun cyc=%0d got=%b/%0d want=%b/%0d", c, OVERRUNo, DROP_CNTo,
                 m_ovr, m_drop);
      end
      total++;
      if (c > 0 && IRQ_THRo !== (fifo_q.size() >= thr)) begin
        bad++;
        $display("FAIL rnd_irq cyc=%0d got=%b level=%0d thr=%0d", c, IRQ_THRo, fifo_q.size(),
                 thr);
      end
      if (M_VALIDo && prev_v && !prev_hs) begin
        total++;
        if (M_DATAo !== prev_d) begin
          bad++;
          $display("FAIL rnd_hold cyc=%0d got=%h want=%h", c, M_DATAo, prev_d);
        end
      end
      prev_v  = M_VALIDo;
      prev_d  = M_DATAo;
      prev_hs = M_READYi && !FLUSHi;
    end
    OVR_CLRi = 1'b0;
    FLUSHi   = 1'b0;
    M_READYi = 1'b1;
    idle(50);
    @(negedge CLKip);
    total++;
    if (got_q.size() != exp_log.size()) begin
      bad++;
      $display("FAIL rnd_stream_len got=%0d want=%0d", got_q.size(), exp_log.size());
    end
    fails = 0;
    for (int i = 0; i < got_q.size() && i < exp_log.size(); i++) begin
      if (fails == 0 && got_q[i] !== exp_log[i]) begin
        fails++;
        $display("FAIL rnd_stream idx=%0d got=%h want=%h", i, got_q[i], exp_log[i]);
      end
    end
    total++;
    bad += fails;
    THRESHi = 5'd0;
  endtask

  task automatic test_async_reset();
    M_READYi = 1'b0;
    THRESHi  = 5'd1;
    for (int i = 0; i < 3; i++) begin
      send(8'($urandom_range(1, 255)));
      idle(3);
    end
    @(negedge CLKip);
    total++;
    if (M_VALIDo !== 1'b1 || LEVELo !== 5'd2 || IRQ_THRo !== 1'b1) begin
      bad++;
      $display("FAIL areset_setup valid=%b level=%0d irq=%b want 1/2/1", M_VALIDo, LEVELo,
               IRQ_THRo);
    end
    @(posedge CLKip); #2;
    RSTNi = 1'b0;
    #1;
    total++;
    if ({M_VALIDo, M_DATAo, LEVELo, IRQ_THRo, OVERRUNo, DROP_CNTo, FIFO_RDo} !== 25'b0) begin
      bad++;
      $display("FAIL areset_outputs valid=%b data=%h level=%0d irq=%b want all 0", M_VALIDo,
               M_DATAo, LEVELo, IRQ_THRo);
    end
    THRESHi = 5'd0;
    idle(2);
    RSTNi = 1'b1;
    idle(2);
  endtask

`ifdef RX_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    M_READYi = 1'b0;
    send(8'h33);
    n = 0;
    while (TOUT_IRQo !== 1'b1 && n < 100) begin
      @(negedge CLKip);
      n++;
    end
    total++;
    if (n < 30 || n > 40) begin
      bad++;
      $display("FAIL tout_delay got=%0d cycles want 30..40", n);
    end
    send(8'h34);
    @(negedge CLKip);
    total++;
    if (TOUT_IRQo !== 1'b0) begin
      bad++;
      $display("FAIL tout_drop got=%b want=0", TOUT_IRQo);
    end
  endtask
`endif

  initial begin
    #1 RSTNi = 1'b0;
    idle(3);
    test_reset();
    test_in_order();
    test_hold();
    test_overrun();
    test_flush_full();
    test_flush();
    test_threshold();
    test_back_to_back();
    test_async_reset();
`ifdef RX_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
